jelly_img_canny_param_ctl: RTL

Parameter controller for the Canny edge core. Holds host-written shadow copies of the core's `enable` and `param_th` inputs behind a Wishbone slave port. Transfers them to the live outputs only at an image frame boundary, so a frame is never processed with mixed parameters. Sits between the system register bus and the canny core, and observes the same image stream that feeds the core.

---
 rtl/jelly_img_canny_param_ctl_if.sv | 35 +++
 rtl/jelly_img_canny_param_ctl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/jelly_img_canny_param_ctl_if.sv
// Wishbone slave bus bundle for the canny parameter controller.
// The master modport is the register-bus side; the slave modport is the controller.
interface jelly_img_canny_param_ctl_if #(
    parameter int WB_ADR_WIDTH = 8,
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_SEL_WIDTH = WB_DAT_WIDTH / 8
);
    logic [WB_ADR_WIDTH-1:0] s_wb_adr_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_i;
    logic [WB_DAT_WIDTH-1:0] s_wb_dat_o;
    logic                    s_wb_we_i;
    logic [WB_SEL_WIDTH-1:0] s_wb_sel_i;
    logic                    s_wb_stb_i;
    logic                    s_wb_ack_o;

    modport master (
        output s_wb_adr_i,
        output s_wb_dat_i,
        input  s_wb_dat_o,
        output s_wb_we_i,
        output s_wb_sel_i,
        output s_wb_stb_i,
        input  s_wb_ack_o
    );

    modport slave (
        input  s_wb_adr_i,
        input  s_wb_dat_i,
        output s_wb_dat_o,
        input  s_wb_we_i,
        input  s_wb_sel_i,
        input  s_wb_stb_i,
        output s_wb_ack_o
    );
endinterface

// File: rtl/jelly_img_canny_param_ctl.sv
// Canny parameter controller: host-written shadow registers that are moved to the
// live core inputs only at a frame start, so a frame never sees mixed parameters.
module jelly_img_canny_param_ctl #(
    parameter int                  WB_ADR_WIDTH      = 8,
    parameter int                  WB_DAT_WIDTH      = 32,
    parameter int                  WB_SEL_WIDTH      = WB_DAT_WIDTH / 8,
    parameter int                  TH_WIDTH          = 17,
    parameter logic [31:0]         CORE_ID           = 32'h527a_2310,
    parameter logic [31:0]         CORE_VERSION      = 32'h0001_0000,
    parameter logic                INIT_CTL_AUTO     = 1'b1,
    parameter logic                INIT_PARAM_ENABLE = 1'b0,
    parameter logic [TH_WIDTH-1:0] INIT_PARAM_TH     = TH_WIDTH'(127)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 cke,
    jelly_img_canny_param_ctl_if.slave           s_wb,
    input  logic                                 s_img_line_first,
    input  logic                                 s_img_pixel_first,
    input  logic                                 s_img_de,
    input  logic                                 s_img_valid,
    output logic                                 out_enable,
    output logic [TH_WIDTH-1:0]                  out_param_th,
    output logic                                 out_update
);

    localparam int TH_SEL = (TH_WIDTH + 7) / 8;

    localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_ID      = WB_ADR_WIDTH'(8'h00);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CORE_VERSION = WB_ADR_WIDTH'(8'h01);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_CONTROL  = WB_ADR_WIDTH'(8'h04);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_STATUS   = WB_ADR_WIDTH'(8'h05);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CTL_INDEX    = WB_ADR_WIDTH'(8'h06);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_ENABLE = WB_ADR_WIDTH'(8'h08);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_PARAM_TH     = WB_ADR_WIDTH'(8'h09);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CUR_ENABLE   = WB_ADR_WIDTH'(8'h18);
    localparam logic [WB_ADR_WIDTH-1:0] ADR_CUR_TH       = WB_ADR_WIDTH'(8'h19);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_auto;
    logic                    r_param_enable;
    logic [TH_WIDTH-1:0]     r_param_th;
    logic                    r_out_enable;
    logic [TH_WIDTH-1:0]     r_out_th;
    logic                    r_update;
    logic [15:0]             r_index;
    logic [WB_DAT_WIDTH-1:0] w_rdata;
    logic                    w_pending;
    logic                    w_fs;
    logic                    w_apply;
    logic                    w_wr;
    logic                    w_wr_ctl;
    logic                    w_set_req;
    logic                    w_unused;

    // Byte-lane merge of a write into the threshold field; lanes with sel low keep the old bits.
    function automatic logic [TH_WIDTH-1:0] merge_th(
        input logic [TH_WIDTH-1:0] old_v,
        input logic [TH_WIDTH-1:0] dat,
        input logic [TH_SEL-1:0]   sel
    );
        logic [TH_WIDTH-1:0] v;
        v = old_v;
        for (int b = 0; b < TH_WIDTH; b++) begin
            if (sel[b / 8]) begin
                v[b] = dat[b];
            end else begin
                v[b] = old_v[b];
            end
        end
        return v;
    endfunction

    assign w_pending = (r_state == ST_ARMED);
    assign w_fs      = cke & s_img_valid & s_img_de & s_img_line_first & s_img_pixel_first;
    assign w_apply   = w_fs & (w_pending | r_auto);
    assign w_wr      = s_wb.s_wb_stb_i & s_wb.s_wb_we_i;
    assign w_wr_ctl  = w_wr & (s_wb.s_wb_adr_i == ADR_CTL_CONTROL) & s_wb.s_wb_sel_i[0];
    assign w_set_req = w_wr_ctl & s_wb.s_wb_dat_i[0];
    assign w_unused  = ^{s_wb.s_wb_dat_i, s_wb.s_wb_sel_i};

    // Pending-update state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A host request written in the apply cycle wins over the clear.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_set_req) begin
                    w_state_next = ST_ARMED;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_set_req) begin
                    w_state_next = ST_ARMED;
                end else if (w_apply) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ARMED;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Host-writable shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_auto         <= INIT_CTL_AUTO;
            r_param_enable <= INIT_PARAM_ENABLE;
            r_param_th     <= INIT_PARAM_TH;
        end else begin
            if (w_wr_ctl) begin
                r_auto <= s_wb.s_wb_dat_i[1];
            end
            if (w_wr && (s_wb.s_wb_adr_i == ADR_PARAM_ENABLE) && s_wb.s_wb_sel_i[0]) begin
                r_param_enable <= s_wb.s_wb_dat_i[0];
            end
            if (w_wr && (s_wb.s_wb_adr_i == ADR_PARAM_TH)) begin
                r_param_th <= merge_th(r_param_th, s_wb.s_wb_dat_i[TH_WIDTH-1:0],
                                       s_wb.s_wb_sel_i[TH_SEL-1:0]);
            end
        end
    end

    // Frame-boundary transfer; the copy sees the shadow values from before any same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_enable <= INIT_PARAM_ENABLE;
            r_out_th     <= INIT_PARAM_TH;
            r_index      <= 16'd0;
            r_update     <= 1'b0;
        end else begin
            r_update <= w_apply;
            if (w_apply) begin
                r_out_enable <= r_param_enable;
                r_out_th     <= r_param_th;
                r_index      <= r_index + 16'd1;
            end
        end
    end

    // Read decode; the bus reads zero whenever no access is in progress.
    always_comb begin
        w_rdata = '0;
        if (s_wb.s_wb_stb_i) begin
            case (s_wb.s_wb_adr_i)
                ADR_CORE_ID:      w_rdata = WB_DAT_WIDTH'(CORE_ID);
                ADR_CORE_VERSION: w_rdata = WB_DAT_WIDTH'(CORE_VERSION);
                ADR_CTL_CONTROL:  w_rdata = WB_DAT_WIDTH'({r_auto, w_pending});
                ADR_CTL_STATUS:   w_rdata = WB_DAT_WIDTH'(w_pending | r_auto);
                ADR_CTL_INDEX:    w_rdata = WB_DAT_WIDTH'(r_index);
                ADR_PARAM_ENABLE: w_rdata = WB_DAT_WIDTH'(r_param_enable);
                ADR_PARAM_TH:     w_rdata = WB_DAT_WIDTH'(r_param_th);
                ADR_CUR_ENABLE:   w_rdata = WB_DAT_WIDTH'(r_out_enable);
                ADR_CUR_TH:       w_rdata = WB_DAT_WIDTH'(r_out_th);
                default:          w_rdata = '0;
            endcase
        end else begin
            w_rdata = '0;
        end
    end

    assign s_wb.s_wb_dat_o = w_rdata;
    assign s_wb.s_wb_ack_o = s_wb.s_wb_stb_i;
    assign out_enable      = r_out_enable;
    assign out_param_th    = r_out_th;
    assign out_update      = r_update;

endmodule
